// File: rtl/ysyx_22040931_mem_stage.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_mem_stage
//
// Memory-access stage of the ysyx_22040931 RV64 pipeline, sitting between EX
// and WB. Non-memory packets pass straight through to a registered writeback
// packet. Loads and stores are issued one at a time on a valid/ready memory
// bus with byte-lane alignment, then the load result is extracted and
// sign/zero extended. Misaligned or reserved-op accesses never reach the bus
// and retire immediately with the misalign flag set.
//
// Handshakes (all sampled on the rising edge of clk):
//   - EX -> MEM : a packet transfers when in_valid && in_ready. in_ready is
//                 high only in IDLE; upstream holds the packet otherwise.
//   - MEM -> bus: a request transfers when bus_req_valid && bus_req_ready.
//                 bus_addr/wen/wmask/wdata stay constant while valid waits.
//   - bus -> MEM: bus_rsp_valid is a one-cycle response (read data or write
//                 acknowledge), honoured only in WAIT.
//   - MEM -> WB : wb_valid is a one-cycle pulse; WB never stalls.
//
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   in_valid / in_ready     EX packet handshake
//   w_ena_i, w_addr_i,
//   w_data_i, pc_i          regfile write intent, EX result, instruction PC
//   mem_ena_i, mem_wr_i,
//   memrop_i, memwop_i      memory access enable, direction and size/sign op
//   mem_addr_i, mem_data_i  byte address and right-aligned store data
//   bus_req_*/bus_addr/
//   bus_wen/bus_wmask/
//   bus_wdata               request channel to memory (doubleword aligned)
//   bus_rsp_valid/bus_rdata response channel from memory
//   wb_*                    registered writeback packet to WB
//   misalign                misaligned/reserved access, pulses with wb_valid
// ----------------------------------------------------------------------------
module ysyx_22040931_mem_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int PC_W   = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              w_ena_i,
    input  logic [4:0]        w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              mem_ena_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        memrop_i,
    input  logic [2:0]        memwop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wen,
    output logic [7:0]        bus_wmask,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              wb_valid,
    output logic              wb_w_ena,
    output logic [4:0]        wb_w_addr,
    output logic [DATA_W-1:0] wb_w_data,
    output logic [PC_W-1:0]   wb_pc,
    output logic              misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // Accept-time decode of the incoming EX packet
    // ------------------------------------------------------------------
    logic              accept;
    logic [1:0]        acc_size;      // log2 of access bytes
    logic              acc_reserved;
    logic              acc_aligned;
    logic              acc_misalign;
    logic              acc_go_mem;    // accepted packet that needs the bus
    logic [7:0]        acc_size_mask;
    logic [7:0]        acc_wmask;
    logic [DATA_W-1:0] acc_wdata;

    assign accept       = in_valid && in_ready;
    assign acc_size     = mem_wr_i ? memwop_i[1:0] : memrop_i[1:0];
    assign acc_reserved = mem_wr_i ? memwop_i[2] : (memrop_i == 3'b111);

    always_comb begin
        acc_aligned   = 1'b1;
        acc_size_mask = 8'h01;
        case (acc_size)
            2'd0: begin
                acc_aligned   = 1'b1;
                acc_size_mask = 8'h01;
            end
            2'd1: begin
                acc_aligned   = (mem_addr_i[0] == 1'b0);
                acc_size_mask = 8'h03;
            end
            2'd2: begin
                acc_aligned   = (mem_addr_i[1:0] == 2'b00);
                acc_size_mask = 8'h0F;
            end
            default: begin
                acc_aligned   = (mem_addr_i[2:0] == 3'b000);
                acc_size_mask = 8'hFF;
            end
        endcase
    end

    assign acc_misalign = mem_ena_i && (acc_reserved || !acc_aligned);
    assign acc_go_mem   = accept && mem_ena_i && !acc_misalign;

    // Store data moves up to its byte lane; upper bits spill out of the
    // doubleword and the mask decides which lanes memory actually writes.
    assign acc_wmask = mem_wr_i ? (acc_size_mask << mem_addr_i[2:0]) : 8'h00;
    assign acc_wdata = mem_wr_i ? (mem_data_i << {mem_addr_i[2:0], 3'b000})
                                : '0;

    // ------------------------------------------------------------------
    // In-flight access registers (valid from REQ through WAIT)
    // ------------------------------------------------------------------
    logic              wr_q;
    logic [2:0]        rop_q;
    logic [2:0]        shift_q;
    logic              w_ena_q;
    logic [4:0]        w_addr_q;
    logic [PC_W-1:0]   pc_q;
    logic [ADDR_W-4:0] addr_q;        // doubleword index, low 3 bits implied 0
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= 1'b0;
            rop_q    <= 3'b000;
            shift_q  <= 3'b000;
            w_ena_q  <= 1'b0;
            w_addr_q <= 5'd0;
            pc_q     <= '0;
            addr_q   <= '0;
            wmask_q  <= 8'h00;
            wdata_q  <= '0;
        end else if (acc_go_mem) begin
            wr_q     <= mem_wr_i;
            rop_q    <= memrop_i;
            shift_q  <= mem_addr_i[2:0];
            w_ena_q  <= w_ena_i;
            w_addr_q <= w_addr_i;
            pc_q     <= pc_i;
            addr_q   <= mem_addr_i[ADDR_W-1:3];
            wmask_q  <= acc_wmask;
            wdata_q  <= acc_wdata;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_go_mem)    state_d = REQ;
            REQ:     if (bus_req_ready) state_d = WAIT;
            WAIT:    if (bus_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are driven only in REQ so the bus sees zeros when idle.
    always_comb begin
        in_ready      = 1'b0;
        bus_req_valid = 1'b0;
        bus_addr      = '0;
        bus_wen       = 1'b0;
        bus_wmask     = 8'h00;
        bus_wdata     = '0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            REQ: begin
                bus_req_valid = 1'b1;
                bus_addr      = {addr_q, 3'b000};
                bus_wen       = wr_q;
                bus_wmask     = wmask_q;
                bus_wdata     = wdata_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load data extraction
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] load_data;

    assign rd_shifted = bus_rdata >> {shift_q, 3'b000};

    always_comb begin
        load_data = rd_shifted;
        case (rop_q)
            3'b000:  load_data = {{(DATA_W-8){rd_shifted[7]}},   rd_shifted[7:0]};
            3'b001:  load_data = {{(DATA_W-16){rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  load_data = {{(DATA_W-32){rd_shifted[31]}}, rd_shifted[31:0]};
            3'b100:  load_data = {{(DATA_W-8){1'b0}},            rd_shifted[7:0]};
            3'b101:  load_data = {{(DATA_W-16){1'b0}},           rd_shifted[15:0]};
            3'b110:  load_data = {{(DATA_W-32){1'b0}},           rd_shifted[31:0]};
            default: load_data = rd_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Writeback packet. Retires either straight from accept (non-memory or
    // misaligned) or on the bus response. Stores and misaligned accesses
    // carry a zero data field since nothing is written back.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_w_ena  <= 1'b0;
            wb_w_addr <= 5'd0;
            wb_w_data <= '0;
            wb_pc     <= '0;
            misalign  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_w_ena <= 1'b0;
            misalign <= 1'b0;
            if (accept && !acc_go_mem) begin
                wb_valid  <= 1'b1;
                wb_w_ena  <= w_ena_i && !mem_ena_i;
                wb_w_addr <= w_addr_i;
                wb_w_data <= mem_ena_i ? '0 : w_data_i;
                wb_pc     <= pc_i;
                misalign  <= acc_misalign;
            end else if (state_q == WAIT && bus_rsp_valid) begin
                wb_valid  <= 1'b1;
                wb_w_ena  <= w_ena_q && !wr_q;
                wb_w_addr <= w_addr_q;
                wb_w_data <= wr_q ? '0 : load_data;
                wb_pc     <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_mem_stage.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_22040931_mem_stage: reset values, pass-through packets,
// a table of load/store/misaligned accesses with a bus responder task, and
// hand-written sequences for delayed handshakes and reset mid-access.
// Writeback packets are checked against an expected queue filled at accept.
// ----------------------------------------------------------------------------
module tb_ysyx_22040931_mem_stage;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int PW = 64;
    // {chk_data, misalign, w_ena, w_addr[4:0], w_data[63:0], pc[63:0]}
    localparam int EW = 136;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          w_ena_i;
    logic [4:0]    w_addr_i;
    logic [DW-1:0] w_data_i;
    logic [PW-1:0] pc_i;
    logic          mem_ena_i;
    logic          mem_wr_i;
    logic [2:0]    memrop_i;
    logic [2:0]    memwop_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_data_i;
    logic          bus_req_valid;
    logic          bus_req_ready;
    logic [AW-1:0] bus_addr;
    logic          bus_wen;
    logic [7:0]    bus_wmask;
    logic [DW-1:0] bus_wdata;
    logic          bus_rsp_valid;
    logic [DW-1:0] bus_rdata;
    logic          wb_valid;
    logic          wb_w_ena;
    logic [4:0]    wb_w_addr;
    logic [DW-1:0] wb_w_data;
    logic [PW-1:0] wb_pc;
    logic          misalign;

    ysyx_22040931_mem_stage #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .w_ena_i(w_ena_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .pc_i(pc_i),
        .mem_ena_i(mem_ena_i), .mem_wr_i(mem_wr_i),
        .memrop_i(memrop_i), .memwop_i(memwop_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wmask(bus_wmask),
        .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_w_ena(wb_w_ena), .wb_w_addr(wb_w_addr),
        .wb_w_data(wb_w_data), .wb_pc(wb_pc), .misalign(misalign)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;
    logic [EW-1:0] exp_q[$];
    int acc_q[$];
    int lat_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        int a;
        int l;
        if (mon_en) begin
            check("misalign_pulse", 64'(misalign && !wb_valid), 64'd0);
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wb_valid", 64'(wb_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    l = lat_q.pop_front();
                    check("wb_misalign", 64'(misalign), 64'(e[134]));
                    check("wb_w_ena", 64'(wb_w_ena), 64'(e[133]));
                    check("wb_w_addr", 64'(wb_w_addr), 64'(e[132:128]));
                    if (e[135]) check("wb_w_data", wb_w_data, e[127:64]);
                    check("wb_pc", wb_pc, e[63:0]);
                    check("wb_latency", 64'(cyc - a + 1), 64'(l));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one EX packet, waits (bounded) for acceptance and records the
    // expected writeback with the accept cycle and expected latency.
    task automatic send(input logic mem_ena, input logic wr, input logic [2:0] rop,
                        input logic [2:0] wop, input logic [31:0] addr,
                        input logic [63:0] sdata, input logic wena,
                        input logic [4:0] waddr, input logic [63:0] wdata,
                        input logic [63:0] pc, input logic [EW-1:0] exp, input int lat);
        int n;
        mem_ena_i  = mem_ena;
        mem_wr_i   = wr;
        memrop_i   = rop;
        memwop_i   = wop;
        mem_addr_i = addr;
        mem_data_i = sdata;
        w_ena_i    = wena;
        w_addr_i   = waddr;
        w_data_i   = wdata;
        pc_i       = pc;
        in_valid   = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            exp_q.push_back(exp);
            acc_q.push_back(cyc);
            lat_q.push_back(lat);
        end
    endtask

    // Acts as memory for one access already in REQ. Stray rsp during REQ and
    // stray ready during WAIT must be ignored by the stage.
    task automatic serve_bus(input logic [31:0] addr, input logic wr, input logic [7:0] mask,
                             input logic [63:0] bwdata, input logic [63:0] rdata,
                             input int rdy_dly, input int rsp_dly);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:3], 3'b000};
        for (int i = 0; i <= rdy_dly; i++) begin
            bus_req_ready = (i == rdy_dly);
            bus_rsp_valid = (i < rdy_dly);
            bus_rdata     = ~rdata;
            check("req_valid", 64'(bus_req_valid), 64'd1);
            check("req_in_ready", 64'(in_ready), 64'd0);
            check("bus_addr", 64'(bus_addr), 64'(exp_addr));
            check("bus_wen", 64'(bus_wen), 64'(wr));
            check("bus_wmask", 64'(bus_wmask), 64'(mask));
            check("bus_wdata", bus_wdata, bwdata);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i <= rsp_dly; i++) begin
            bus_rsp_valid = (i == rsp_dly);
            bus_req_ready = (i < rsp_dly);
            bus_rdata     = (i == rsp_dly) ? rdata : ~rdata;
            check("wait_req_valid", 64'(bus_req_valid), 64'd0);
            check("wait_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus_rsp_valid = 1'b0;
        bus_req_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        logic        wena;
        logic        mis;
        logic        xwena;
        logic [63:0] xwb;
        logic [7:0]  xmask;
        logic [63:0] xbw;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                                input logic [63:0] sdata, input logic [63:0] rdata,
                                input logic wena, input logic mis, input logic xwena,
                                input logic [63:0] xwb, input logic [7:0] xmask,
                                input logic [63:0] xbw);
        vec_t v;
        v.wr = wr; v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.wena = wena; v.mis = mis; v.xwena = xwena; v.xwb = xwb;
        v.xmask = xmask; v.xbw = xbw;
        return v;
    endfunction

    localparam logic [63:0] R1 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] R2 = 64'hF0E1_D2C3_B4A5_9687;
    localparam logic [63:0] R3 = 64'h1234_5678_7ABC_DEF0;

    // ---------------- main sequence ----------------
    initial begin : main
        logic [EW-1:0] e;
        logic [63:0]   pc;
        logic [63:0]   d;
        logic [4:0]    wa;
        logic          we;
        int rd;
        int sd;
        int c0;

        //            wr  op      addr          sdata                  rdata wena mis xwena xwb                     xmask  xbw
        vecs[0]  = mk(0, 3'b000, 32'h8000_0003, 64'h0,                 R1,   1, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0);
        vecs[1]  = mk(0, 3'b100, 32'h8000_0003, 64'h0,                 R1,   1, 0, 1, 64'h0000_0000_0000_0080, 8'h00, 64'h0);
        vecs[2]  = mk(0, 3'b001, 32'h8000_0002, 64'h0,                 R2,   1, 0, 1, 64'hFFFF_FFFF_FFFF_B4A5, 8'h00, 64'h0);
        vecs[3]  = mk(0, 3'b101, 32'h8000_0006, 64'h0,                 R2,   1, 0, 1, 64'h0000_0000_0000_F0E1, 8'h00, 64'h0);
        vecs[4]  = mk(0, 3'b010, 32'h8000_0004, 64'h0,                 R2,   1, 0, 1, 64'hFFFF_FFFF_F0E1_D2C3, 8'h00, 64'h0);
        vecs[5]  = mk(0, 3'b110, 32'h8000_0004, 64'h0,                 R2,   1, 0, 1, 64'h0000_0000_F0E1_D2C3, 8'h00, 64'h0);
        vecs[6]  = mk(0, 3'b010, 32'h8000_0000, 64'h0,                 R3,   1, 0, 1, 64'h0000_0000_7ABC_DEF0, 8'h00, 64'h0);
        vecs[7]  = mk(0, 3'b011, 32'h8000_0008, 64'h0,                 R2,   1, 0, 1, R2,                      8'h00, 64'h0);
        vecs[8]  = mk(0, 3'b000, 32'h8000_0007, 64'h0,                 R2,   1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 8'h00, 64'h0);
        vecs[9]  = mk(0, 3'b101, 32'h8000_0000, 64'h0,                 R2,   0, 0, 0, 64'h0000_0000_0000_9687, 8'h00, 64'h0);
        vecs[10] = mk(0, 3'b000, 32'h8000_0003, 64'h0,                 R3,   1, 0, 1, 64'h0000_0000_0000_007A, 8'h00, 64'h0);
        vecs[11] = mk(1, 3'b001, 32'h8000_0006, 64'h0000_0000_0000_ABCD, 64'h0, 1, 0, 0, 64'h0, 8'hC0, 64'hABCD_0000_0000_0000);
        vecs[12] = mk(1, 3'b000, 32'h8000_0005, 64'h1111_2222_3333_445A, 64'h0, 1, 0, 0, 64'h0, 8'h20, 64'h3344_5A00_0000_0000);
        vecs[13] = mk(1, 3'b010, 32'h8000_0004, 64'h0000_0000_DEAD_BEEF, 64'h0, 1, 0, 0, 64'h0, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        vecs[14] = mk(1, 3'b011, 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 0, 0, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        vecs[15] = mk(1, 3'b010, 32'h8000_0008, 64'hFFFF_FFFF_1357_9BDF, 64'h0, 1, 0, 0, 64'h0, 8'h0F, 64'hFFFF_FFFF_1357_9BDF);
        vecs[16] = mk(0, 3'b010, 32'h8000_0002, 64'h0, R2, 1, 1, 0, 64'h0, 8'h00, 64'h0);
        vecs[17] = mk(0, 3'b111, 32'h8000_0000, 64'h0, R2, 1, 1, 0, 64'h0, 8'h00, 64'h0);
        vecs[18] = mk(0, 3'b001, 32'h8000_0001, 64'h0, R2, 1, 1, 0, 64'h0, 8'h00, 64'h0);
        vecs[19] = mk(0, 3'b011, 32'h8000_0004, 64'h0, R2, 1, 1, 0, 64'h0, 8'h00, 64'h0);
        vecs[20] = mk(1, 3'b001, 32'h8000_0003, 64'h5, 64'h0, 1, 1, 0, 64'h0, 8'h00, 64'h0);
        vecs[21] = mk(1, 3'b011, 32'h8000_0001, 64'h5, 64'h0, 1, 1, 0, 64'h0, 8'h00, 64'h0);
        vecs[22] = mk(1, 3'b100, 32'h8000_0000, 64'h5, 64'h0, 1, 1, 0, 64'h0, 8'h00, 64'h0);
        vecs[23] = mk(0, 3'b110, 32'h8000_0006, 64'h0, R2, 1, 1, 0, 64'h0, 8'h00, 64'h0);

        rst = 1'b1;
        in_valid = 1'b0; w_ena_i = 1'b0; w_addr_i = 5'd0; w_data_i = '0; pc_i = '0;
        mem_ena_i = 1'b0; mem_wr_i = 1'b0; memrop_i = 3'b000; memwop_i = 3'b000;
        mem_addr_i = '0; mem_data_i = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_w_ena", 64'(wb_w_ena), 64'd0);
        check("rst_req_valid", 64'(bus_req_valid), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        check("rst_bus_wmask", 64'(bus_wmask), 64'd0);
        check("rst_bus_wdata", bus_wdata, 64'd0);
        check("rst_wb_w_data", wb_w_data, 64'd0);
        check("rst_wb_pc", wb_pc, 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // ---- non-memory packet from the plan ----
        e = {1'b1, 1'b0, 1'b1, 5'd5, 64'h1234, 64'h8000_0000};
        send(0, 0, 3'b000, 3'b000, 32'h0, 64'h0, 1, 5'd5, 64'h1234, 64'h8000_0000, e, 1);
        check("nonmem_no_req", 64'(bus_req_valid), 64'd0);

        // ---- back-to-back non-memory packets with junk memory fields ----
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            d  = {$urandom, $urandom};
            wa = 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            pc = 64'h8000_0004 + 64'(4 * i);
            e  = {1'b1, 1'b0, we, wa, d, pc};
            send(0, 1'($urandom_range(0, 1)), 3'b010, 3'b011, 32'h8000_0001,
                 {$urandom, $urandom}, we, wa, d, pc, e, 1);
        end
        check("b2b_cycles", 64'(cyc - c0), 64'd6);

        // ---- table of memory accesses ----
        for (int i = 0; i < NV; i++) begin
            pc = 64'h8000_0100 + 64'(4 * i);
            wa = 5'(i + 1);
            rd = $urandom_range(0, 2);
            sd = $urandom_range(0, 2);
            e  = {!vecs[i].wr && !vecs[i].mis, vecs[i].mis, vecs[i].xwena, wa, vecs[i].xwb, pc};
            send(1, vecs[i].wr, vecs[i].wr ? 3'b000 : vecs[i].op, vecs[i].wr ? vecs[i].op : 3'b000,
                 vecs[i].addr, vecs[i].sdata, vecs[i].wena, wa, 64'hDEAD_0000 + 64'(i), pc, e,
                 vecs[i].mis ? 1 : 3 + rd + sd);
            if (vecs[i].mis) begin
                check("mis_no_req", 64'(bus_req_valid), 64'd0);
                check("mis_in_ready", 64'(in_ready), 64'd1);
            end else begin
                serve_bus(vecs[i].addr, vecs[i].wr, vecs[i].xmask, vecs[i].xbw, vecs[i].rdata, rd, sd);
            end
        end

        // ---- LD with ready delayed 3 and rsp delayed 2 ----
        d  = {$urandom, $urandom};
        pc = 64'h8000_0200;
        e  = {1'b1, 1'b0, 1'b1, 5'd17, d, pc};
        send(1, 0, 3'b011, 3'b000, 32'h8000_0010, 64'h0, 1, 5'd17, 64'h0, pc, e, 8);
        serve_bus(32'h8000_0010, 1'b0, 8'h00, 64'h0, d, 3, 2);

        // ---- reset while in WAIT, then a stale response ----
        e = {1'b1, 1'b0, 1'b1, 5'd9, 64'h0, 64'h8000_0300};
        send(1, 0, 3'b011, 3'b000, 32'h8000_0018, 64'h0, 1, 5'd9, 64'h0, 64'h8000_0300, e, 3);
        bus_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_req_ready = 1'b0;
        check("wait_before_rst", 64'(bus_req_valid), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstwait_in_ready", 64'(in_ready), 64'd1);
        check("rstwait_req_valid", 64'(bus_req_valid), 64'd0);
        check("rstwait_wb_valid", 64'(wb_valid), 64'd0);
        bus_rsp_valid = 1'b1;
        bus_rdata = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk);
        #1;
        bus_rsp_valid = 1'b0;
        check("stale_rsp_wb_valid", 64'(wb_valid), 64'd0);
        check("stale_rsp_in_ready", 64'(in_ready), 64'd1);

        // ---- reset while in REQ, then a stray ready ----
        e = {1'b1, 1'b0, 1'b1, 5'd10, 64'h0, 64'h8000_0400};
        send(1, 1, 3'b000, 3'b011, 32'h8000_0020, 64'h77, 1, 5'd10, 64'h0, 64'h8000_0400, e, 3);
        check("req_before_rst", 64'(bus_req_valid), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstreq_req_valid", 64'(bus_req_valid), 64'd0);
        check("rstreq_in_ready", 64'(in_ready), 64'd1);
        bus_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_req_ready = 1'b0;
        check("stray_ready_in_ready", 64'(in_ready), 64'd1);
        check("stray_ready_req_valid", 64'(bus_req_valid), 64'd0);

        // ---- recovery: one more pass-through packet ----
        e = {1'b1, 1'b0, 1'b1, 5'd31, 64'hCAFE_F00D, 64'h8000_0500};
        send(0, 0, 3'b000, 3'b000, 32'h0, 64'h0, 1, 5'd31, 64'hCAFE_F00D, 64'h8000_0500, e, 1);

        repeat (3) @(posedge clk);
        #1;
        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
